text_rx_buffer: RTL and testbench

Receive-side counterpart of the text transmit path. Accepts the framed ASCII byte stream produced by the text source after the channel, strips the STX/EOT framing, and stores the payload in an internal buffer. Verifies an XOR checksum and reports message length and status. Exposes a synchronous read port so display or compare logic can fetch the recovered text.

---
 rtl/text_rx_buffer.sv | 137 +++++++++++++
 tb/tb_text_rx_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_rx_buffer.sv
// Receive buffer for framed ASCII text: strips STX/EOT, stores the payload,
// checks the trailing XOR checksum and exposes a registered read port.
module text_rx_buffer #(
  parameter int          ADDR_W = 8,
  parameter logic [7:0]  SOF    = 8'h02,
  parameter logic [7:0]  EOF    = 8'h04
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ack,
  output logic              msg_done,
  output logic              msg_ok,
  output logic              overflow,
  output logic [ADDR_W:0]   msg_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready is low only while a completed frame waits for ack.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [7:0]      run_xor, xor_next;
  logic [ADDR_W:0] len_next;
  logic            ovf_next, ok_next, done_next;
  logic            wr_en;
  logic            accept;
  logic [7:0]      mem [DEPTH];

  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_comb begin
    state_next = state;
    len_next   = msg_len;
    xor_next   = run_xor;
    ovf_next   = overflow;
    ok_next    = msg_ok;
    done_next  = msg_done;
    wr_en      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && in_data == SOF) begin
          state_next = PAYLOAD;
          len_next   = '0;
          xor_next   = '0;
          ovf_next   = 1'b0;
          ok_next    = 1'b0;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          if (in_data == EOF) begin
            state_next = CHECK;
          end else if (in_data == SOF) begin
            // A fresh STX abandons the partial frame and starts over.
            len_next = '0;
            xor_next = '0;
            ovf_next = 1'b0;
            ok_next  = 1'b0;
          end else begin
            xor_next = run_xor ^ in_data;
            if (msg_len < LEN_MAX) begin
              wr_en    = 1'b1;
              len_next = msg_len + 1'b1;
            end else begin
              ovf_next = 1'b1;
            end
          end
        end
      end
      CHECK: begin
        if (accept) begin
          ok_next    = (in_data == run_xor) && !overflow;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (ack) begin
          done_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      msg_done <= 1'b0;
      msg_ok   <= 1'b0;
      overflow <= 1'b0;
      msg_len  <= '0;
      run_xor  <= '0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != DONE);
      msg_done <= done_next;
      msg_ok   <= ok_next;
      overflow <= ovf_next;
      msg_len  <= len_next;
      run_xor  <= xor_next;
    end
  end

  // Buffer contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[msg_len[ADDR_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_text_rx_buffer.sv
// Bench for text_rx_buffer: directed frames from the test plan plus random
// frames, each checked against a byte-stream model of the framing rules.
module tb_text_rx_buffer;

  localparam int         ADDR_W = 2;
  localparam int         DEPTH  = 2**ADDR_W;
  localparam logic [7:0] SOF    = 8'h02;
  localparam logic [7:0] EOF    = 8'h04;

  logic              clk;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ack;
  logic              msg_done;
  logic              msg_ok;
  logic              overflow;
  logic [ADDR_W:0]   msg_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [1:0]        dbg_state;

  text_rx_buffer #(.ADDR_W(ADDR_W), .SOF(SOF), .EOF(EOF)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ack(ack), .msg_done(msg_done), .msg_ok(msg_ok),
    .overflow(overflow), .msg_len(msg_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] frame_q[$];
  logic [7:0] exp_q[$];
  int         exp_len;
  bit         exp_ok;
  bit         exp_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: interpret the whole byte stream in frame_q.
  task automatic compute_expected();
    logic [7:0] pay[$];
    logic [7:0] x;
    logic [7:0] cks;
    bit         in_frame;
    bit         seen_eof;
    in_frame = 0;
    seen_eof = 0;
    cks = 8'h00;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (seen_eof) begin
        cks = frame_q[i];
        break;
      end
      if (!in_frame) begin
        if (frame_q[i] == SOF) begin
          in_frame = 1;
          pay.delete();
        end
      end else if (frame_q[i] == SOF) begin
        pay.delete();
      end else if (frame_q[i] == EOF) begin
        seen_eof = 1;
      end else begin
        pay.push_back(frame_q[i]);
      end
    end
    x = 8'h00;
    foreach (pay[i]) x = x ^ pay[i];
    exp_ovf = (pay.size() > DEPTH);
    exp_len = exp_ovf ? DEPTH : pay.size();
    exp_ok  = (cks == x) && !exp_ovf;
    exp_q.delete();
    for (int i = 0; i < exp_len; i++) exp_q.push_back(pay[i]);
  endtask

  // driver tasks (called at a negedge, return at a negedge)
  task automatic send_byte(input logic [7:0] b, input bit gap);
    chk("in_ready_before_byte", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
    if (gap && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic check_done();
    chk("msg_done", msg_done, 1'b1);
    chk("in_ready_done", in_ready, 1'b0);
    chk("msg_ok", msg_ok, exp_ok);
    chk("msg_len", msg_len, exp_len);
    chk("overflow", overflow, exp_ovf);
  endtask

  task automatic read_back();
    for (int i = 0; i < exp_len; i++) begin
      rd_addr = ADDR_W'(i);
      @(posedge clk);
      @(negedge clk);
      chk("rd_data", rd_data, exp_q[i]);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    chk("msg_done_after_ack", msg_done, 1'b0);
    chk("in_ready_after_ack", in_ready, 1'b1);
    chk("msg_len_held", msg_len, exp_len);
    chk("msg_ok_held", msg_ok, exp_ok);
    chk("overflow_held", overflow, exp_ovf);
  endtask

  task automatic run_frame(input bit gaps);
    compute_expected();
    for (int i = 0; i < frame_q.size(); i++)
      send_byte(frame_q[i], gaps && (i != frame_q.size() - 1));
    check_done();
    read_back();
  endtask

  task automatic backpressure(input int n);
    in_valid = 1'b1;
    in_data  = SOF;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_msg_done", msg_done, 1'b1);
      chk("bp_msg_len", msg_len, exp_len);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_msg_done"}, msg_done, 1'b0);
    chk({tag, "_msg_ok"}, msg_ok, 1'b0);
    chk({tag, "_overflow"}, overflow, 1'b0);
    chk({tag, "_msg_len"}, msg_len, 0);
    chk({tag, "_rd_data"}, rd_data, 8'h00);
  endtask

  function automatic logic [7:0] rand_payload_byte();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (b == SOF || b == EOF);
    return b;
  endfunction

  task automatic build_random_frame();
    logic [7:0] x;
    int n;
    frame_q.delete();
    repeat ($urandom_range(0, 2)) begin
      logic [7:0] j;
      do j = 8'($urandom_range(0, 255)); while (j == SOF);
      frame_q.push_back(j);
    end
    frame_q.push_back(SOF);
    if ($urandom_range(0, 4) == 0) begin
      repeat ($urandom_range(0, 3)) frame_q.push_back(rand_payload_byte());
      frame_q.push_back(SOF);
    end
    n = $urandom_range(0, 6);
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = rand_payload_byte();
      x = x ^ b;
      frame_q.push_back(b);
    end
    frame_q.push_back(EOF);
    frame_q.push_back(($urandom_range(0, 1) == 1) ? x : 8'($urandom_range(0, 255)));
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    ack      = 1'b0;
    rd_addr  = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);

    // good frame, then backpressure while held
    frame_q = '{8'h02, 8'h48, 8'h49, 8'h04, 8'h01};
    run_frame(0);
    backpressure(5);
    do_ack();

    // ack outside DONE changes nothing
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
    chk("idle_ack_in_ready", in_ready, 1'b1);
    chk("idle_ack_msg_done", msg_done, 1'b0);
    chk("idle_ack_msg_len", msg_len, exp_len);

    frame_q = '{8'h02, 8'h48, 8'h49, 8'h04, 8'h00};
    run_frame(0);
    do_ack();
    frame_q = '{8'h02, 8'h04, 8'h00};
    run_frame(0);
    do_ack();
    frame_q = '{8'h02, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h04, 8'h45};
    run_frame(0);
    do_ack();
    frame_q = '{8'h33, 8'h02, 8'h41, 8'h02, 8'h42, 8'h04, 8'h42};
    run_frame(0);
    do_ack();
    frame_q = '{8'h02, 8'h5A, 8'h04, 8'h5A};
    run_frame(0);
    do_ack();

    // reset in the middle of a frame
    send_byte(8'h02, 0);
    send_byte(8'h48, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b1;
    @(negedge clk);
    frame_q = '{8'h02, 8'h4F, 8'h04, 8'h4F};
    run_frame(0);
    do_ack();

    // randomized frames with idle gaps
    for (int k = 0; k < 40; k++) begin
      build_random_frame();
      run_frame(1);
      if ($urandom_range(0, 3) == 0) backpressure($urandom_range(1, 3));
      do_ack();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
